// File: rtl/mcpu_core_pkg.sv
// Shared definitions for the MCPU core ALU path.
// Holds the ALU instruction field map, the opcode and compare-type values that
// carry special meaning, the shift-type encodings and the decoded-word record
// passed from decode to execute. Imported by the decode stage and by the ALU.
package mcpu_core_pkg;

  // Instruction field positions, common to both modes.
  localparam int unsigned InstOpcodeHi = 31;
  localparam int unsigned InstOpcodeLo = 28;
  localparam int unsigned InstCmpHi    = 27;
  localparam int unsigned InstCmpLo    = 25;
  localparam int unsigned InstRdHi     = 24;
  localparam int unsigned InstRdLo     = 20;
  localparam int unsigned InstRsHi     = 19;
  localparam int unsigned InstRsLo     = 15;
  localparam int unsigned InstImmBit   = 14;

  // Register-mode fields ([14] = 0).
  localparam int unsigned InstRtHi      = 13;
  localparam int unsigned InstRtLo      = 9;
  localparam int unsigned InstShTypeHi  = 8;
  localparam int unsigned InstShTypeLo  = 7;
  localparam int unsigned InstShAmtHi   = 6;
  localparam int unsigned InstShAmtLo   = 1;
  localparam int unsigned InstRegRsvBit = 0;

  // Immediate-mode fields ([14] = 1).
  localparam int unsigned InstImmValHi = 13;
  localparam int unsigned InstImmValLo = 4;
  localparam int unsigned InstImmRotHi = 3;
  localparam int unsigned InstImmRotLo = 0;

  // Opcode values with decode-relevant meaning.
  localparam logic [3:0] OpcodeAdd     = 4'b0000;
  localparam logic [3:0] OpcodeCmp     = 4'b0111;
  // 4'b1100 and above are unallocated.
  localparam logic [3:0] OpcodeRsvdMin = 4'b1100;

  // Compare type that is not defined for the compare opcode.
  localparam logic [2:0] CmpTypeRsvd = 3'b011;

  typedef enum logic [1:0] {
    ShiftLsl = 2'b00,
    ShiftLsr = 2'b01,
    ShiftAsr = 2'b10,
    ShiftRor = 2'b11
  } shift_type_e;

  // One decoded ALU word as held in the decode output buffers.
  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] sop;
    logic [3:0]  opcode;
    logic [2:0]  cmp_type;
    shift_type_e shift_type;
    logic [5:0]  shift_amt;
    logic [4:0]  rd;
    logic        invalid;
  } alu_dec_t;

  // Illegal encodings still travel down the pipe; execute acts on the flag.
  function automatic logic alu_inst_illegal(logic [31:0] inst);
    logic [3:0] opcode;
    logic [2:0] cmp_type;
    logic       reg_rsvd;
    opcode   = inst[InstOpcodeHi:InstOpcodeLo];
    cmp_type = inst[InstCmpHi:InstCmpLo];
    reg_rsvd = ~inst[InstImmBit] & inst[InstRegRsvBit];
    return (opcode >= OpcodeRsvdMin) ||
           ((opcode == OpcodeCmp) && (cmp_type == CmpTypeRsvd)) ||
           reg_rsvd;
  endfunction

endpackage

// File: rtl/mcpu_alu_field_decode.sv
// Combinational field decoder for one ALU instruction word.
// Ports:
//   inst_i     - instruction word
//   rs_data_i  - register-file data read at rs_addr_o
//   rt_data_i  - register-file data read at rt_addr_o
//   rs_addr_o  - rs read address
//   rt_addr_o  - rt read address (0 in immediate mode)
//   dec_o      - decoded operands, ALU controls, destination and illegal flag
module mcpu_alu_field_decode
  import mcpu_core_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [4:0]  rs_addr_o,
  output logic [4:0]  rt_addr_o,
  output alu_dec_t    dec_o
);

  logic       imm_mode;
  logic [4:0] rs_addr;
  logic [4:0] rt_addr;

  assign imm_mode  = inst_i[InstImmBit];
  assign rs_addr   = inst_i[InstRsHi:InstRsLo];
  // Immediate mode has no rt; park the port on r0 so it reads nothing useful.
  assign rt_addr   = imm_mode ? 5'd0 : inst_i[InstRtHi:InstRtLo];
  assign rs_addr_o = rs_addr;
  assign rt_addr_o = rt_addr;

  always_comb begin
    dec_o          = '0;
    dec_o.opcode   = inst_i[InstOpcodeHi:InstOpcodeLo];
    dec_o.cmp_type = inst_i[InstCmpHi:InstCmpLo];
    dec_o.rd       = inst_i[InstRdHi:InstRdLo];
    // r0 is hardwired to zero whatever the register file returns.
    dec_o.rs_data  = (rs_addr == 5'd0) ? 32'h0 : rs_data_i;

    if (imm_mode) begin
      dec_o.sop        = {22'h0, inst_i[InstImmValHi:InstImmValLo]};
      dec_o.shift_type = ShiftRor;
      // 4-bit rotate field counts in steps of two.
      dec_o.shift_amt  = {1'b0, inst_i[InstImmRotHi:InstImmRotLo], 1'b0};
    end else begin
      dec_o.sop        = (rt_addr == 5'd0) ? 32'h0 : rt_data_i;
      dec_o.shift_type = shift_type_e'(inst_i[InstShTypeHi:InstShTypeLo]);
      dec_o.shift_amt  = inst_i[InstShAmtHi:InstShAmtLo];
    end

    dec_o.invalid = alu_inst_illegal(inst_i);
  end

endmodule

// File: rtl/mcpu_core_alu_decode.sv
// ALU-class decode stage of the MCPU core.
// Decodes one instruction word per cycle, captures its register operands at
// accept time and presents the result to execute through a two-entry buffer
// (main output register plus skid register), so the upstream ready is a pure
// function of registered state.
// Ports:
//   clkrst_core_clk / clkrst_core_rst_n - clock, async active-low reset
//   f2d_in_valid / f2d_in_inst / f2d_out_ready - instruction handshake
//   rf_rs_addr / rf_rt_addr / rf_rs_data / rf_rt_data - register-file read
//   flush - synchronous kill of everything buffered and any input this cycle
//   d2pc_out_valid / d2pc_in_ready - execute handshake
//   d2pc_out_* - operands, ALU controls, destination, illegal-encoding flag
module mcpu_core_alu_decode
  import mcpu_core_pkg::*;
(
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,
  input  logic        f2d_in_valid,
  input  logic [31:0] f2d_in_inst,
  output logic        f2d_out_ready,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  input  logic        d2pc_in_ready,
  input  logic        flush,
  output logic        d2pc_out_valid,
  output logic [31:0] d2pc_out_rs_data,
  output logic [31:0] d2pc_out_sop,
  output logic [3:0]  d2pc_out_execute_opcode,
  output logic [2:0]  d2pc_out_compare_type,
  output logic [1:0]  d2pc_out_shift_type,
  output logic [5:0]  d2pc_out_shift_amount,
  output logic [4:0]  d2pc_out_rd,
  output logic        d2pc_out_invalid
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } buf_state_e;

  buf_state_e state_q;
  alu_dec_t   main_q;
  alu_dec_t   skid_q;
  alu_dec_t   dec;
  logic       xfer_in;
  logic       xfer_out;

  mcpu_alu_field_decode u_field_decode (
    .inst_i    (f2d_in_inst),
    .rs_data_i (rf_rs_data),
    .rt_data_i (rf_rt_data),
    .rs_addr_o (rf_rs_addr),
    .rt_addr_o (rf_rt_addr),
    .dec_o     (dec)
  );

  // Both handshake outputs depend only on state_q, never on d2pc_in_ready.
  assign f2d_out_ready  = (state_q != StTwo);
  assign d2pc_out_valid = (state_q != StEmpty);

  assign xfer_in  = f2d_in_valid & f2d_out_ready;
  assign xfer_out = d2pc_out_valid & d2pc_in_ready;

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      // Any output transfer this cycle has already completed on the wire;
      // only the buffered words and the incoming word are dropped.
      state_q <= StEmpty;
      main_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (xfer_in) begin
            main_q  <= dec;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (xfer_in && !xfer_out) begin
            // main is stalled; park the new word behind it.
            skid_q  <= dec;
            state_q <= StTwo;
          end else if (xfer_in && xfer_out) begin
            main_q <= dec;
          end else if (xfer_out) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (xfer_out) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign d2pc_out_rs_data        = main_q.rs_data;
  assign d2pc_out_sop            = main_q.sop;
  assign d2pc_out_execute_opcode = main_q.opcode;
  assign d2pc_out_compare_type   = main_q.cmp_type;
  assign d2pc_out_shift_type     = main_q.shift_type;
  assign d2pc_out_shift_amount   = main_q.shift_amt;
  assign d2pc_out_rd             = main_q.rd;
  assign d2pc_out_invalid        = main_q.invalid;

endmodule
